// File: rtl/azadi_io_mux_pkg.sv
// Shared register offsets, reset constants and helpers for the Azadi pad multiplexer.
package azadi_io_mux_pkg;

   localparam int MAX_PADS = 64;

   localparam logic [7:0] OFF_DB_EN_LO    = 8'h40;
   localparam logic [7:0] OFF_DB_EN_HI    = 8'h44;
   localparam logic [7:0] OFF_DB_LIMIT    = 8'h48;
   localparam logic [7:0] OFF_IRQ_EN_LO   = 8'h4C;
   localparam logic [7:0] OFF_IRQ_EN_HI   = 8'h50;
   localparam logic [7:0] OFF_IRQ_STAT_LO = 8'h54;
   localparam logic [7:0] OFF_IRQ_STAT_HI = 8'h58;
   localparam logic [7:0] OFF_PAD_IN_LO   = 8'h5C;
   localparam logic [7:0] OFF_PAD_IN_HI   = 8'h60;

   // Pads come out of reset as inputs driving 0.
   localparam logic RST_OEB = 1'b1;
   localparam logic RST_OUT = 1'b0;

   typedef enum logic {WB_IDLE = 1'b0, WB_ACK = 1'b1} wb_state_e;

   function automatic int fsel_width(input int num_funcs);
      return $clog2(num_funcs);
   endfunction

   // Bits at or above the pad count (and any count beyond MAX_PADS) stay zero.
   function automatic logic [MAX_PADS-1:0] pad_mask(input int num_pads);
      logic [MAX_PADS-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_PADS; i++)
         if (i < num_pads) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      return (old_v & ~byte_mask(sel)) | (new_v & byte_mask(sel));
   endfunction

endpackage

// File: rtl/azadi_io_filter.sv
// One pad input: two-flop synchroniser, optional debounce counter, filter register, rising-edge detect.
// Latency: 3 cycles pad->filt undebounced, 3+db_limit debounced; rise is combinational from filt.
// No backpressure: samples the pad every cycle.
module azadi_io_filter
   import azadi_io_mux_pkg::*;
#(
   parameter int DB_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pad,
   input  logic            db_en,
   input  logic [DB_W-1:0] db_limit,
   output logic            filt,
   output logic            rise
);

   logic            sync_q;
   logic            s_q;
   logic            f_q;
   logic            f_prev_q;
   logic [DB_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 1'b0;
         s_q      <= 1'b0;
         f_q      <= 1'b0;
         f_prev_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= pad;
         s_q      <= sync_q;
         f_prev_q <= f_q;
         if (!db_en || (s_q == f_q)) begin
            cnt_q <= '0;
            if (!db_en) f_q <= s_q;
         end else if (cnt_q == db_limit) begin
            f_q   <= s_q;
            cnt_q <= '0;
         end else if (cnt_q < db_limit) begin
            // Above a freshly lowered limit the count holds until the input settles.
            cnt_q <= cnt_q + DB_W'(1);
         end
      end
   end

   assign filt = f_q;
   assign rise = f_q & ~f_prev_q;

endmodule

// File: rtl/azadi_io_mux.sv
// Wishbone-programmed pad mux: per-pad function select, filtered inputs, rising-edge interrupts.
// Latency: ack 1 cycle after request; periph/FSEL->pad 1 cycle; pad->pad_in_o 3(+DB_LIMIT); edge->irq_o 5.
// No backpressure: single-beat classic Wishbone, ack always follows the next cycle.
module azadi_io_mux
   import azadi_io_mux_pkg::*;
#(
   parameter int          NUM_PADS  = 38,
   parameter int          NUM_FUNCS = 4,
   parameter int          DB_W      = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic                          wbs_stb_i,
   input  logic                          wbs_cyc_i,
   input  logic                          wbs_we_i,
   input  logic [3:0]                    wbs_sel_i,
   input  logic [31:0]                   wbs_adr_i,
   input  logic [31:0]                   wbs_dat_i,
   output logic                          wbs_ack_o,
   output logic [31:0]                   wbs_dat_o,
   input  logic [NUM_FUNCS*NUM_PADS-1:0] periph_o,
   input  logic [NUM_FUNCS*NUM_PADS-1:0] periph_oe,
   output logic [NUM_PADS-1:0]           pad_in_o,
   input  logic [NUM_PADS-1:0]           io_in,
   output logic [NUM_PADS-1:0]           io_out,
   output logic [NUM_PADS-1:0]           io_oeb,
   output logic                          irq_o
);

   localparam int FSEL_W = fsel_width(NUM_FUNCS);
   localparam int FPW    = 32 / FSEL_W;
   localparam int IDX_W  = $clog2(NUM_FUNCS * NUM_PADS);
   localparam logic [MAX_PADS-1:0] PAD_MASK = pad_mask(NUM_PADS);

   wb_state_e state_q, state_d;
   logic      hit, req, wr;
   logic [7:0]  off;
   logic [31:0] rd_d, rd_q;
   logic        unused_adr;

   logic [NUM_PADS-1:0][FSEL_W-1:0] fsel_q, fsel_d;
   logic [MAX_PADS-1:0] db_en_q, db_en_d, irq_en_q, irq_en_d, irq_stat_q, stat_clr;
   logic [MAX_PADS-1:0] rise_x, pad_in_x;
   logic [DB_W-1:0]     db_limit_q, db_limit_d;
   logic [NUM_PADS-1:0] pad_f, pad_rise;

   assign hit        = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign off        = {wbs_adr_i[7:2], 2'b00};
   assign unused_adr = ^wbs_adr_i[1:0];
   assign rise_x     = MAX_PADS'(pad_rise);
   assign pad_in_x   = MAX_PADS'(pad_f);
   assign pad_in_o   = pad_f;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= WB_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         WB_IDLE: if (wbs_stb_i && wbs_cyc_i && hit) state_d = WB_ACK;
         WB_ACK:  state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase
   end

   always_comb begin
      wbs_ack_o = (state_q == WB_ACK);
      req       = (state_q == WB_IDLE) && wbs_stb_i && wbs_cyc_i && hit;
      wr        = req && wbs_we_i;
      wbs_dat_o = wbs_ack_o ? rd_q : 32'h0;
   end

   // Read data is captured on the request edge and presented during the ack cycle.
   always_comb begin
      case (off)
         OFF_DB_EN_LO:    rd_d = db_en_q[31:0];
         OFF_DB_EN_HI:    rd_d = db_en_q[MAX_PADS-1:32];
         OFF_DB_LIMIT:    rd_d = 32'(db_limit_q);
         OFF_IRQ_EN_LO:   rd_d = irq_en_q[31:0];
         OFF_IRQ_EN_HI:   rd_d = irq_en_q[MAX_PADS-1:32];
         OFF_IRQ_STAT_LO: rd_d = irq_stat_q[31:0];
         OFF_IRQ_STAT_HI: rd_d = irq_stat_q[MAX_PADS-1:32];
         OFF_PAD_IN_LO:   rd_d = pad_in_x[31:0];
         OFF_PAD_IN_HI:   rd_d = pad_in_x[MAX_PADS-1:32];
         default:         rd_d = 32'h0;
      endcase
      if (off < OFF_DB_EN_LO) begin
         for (int p = 0; p < NUM_PADS; p++)
            if (p / FPW == int'(wbs_adr_i[7:2]))
               rd_d[FSEL_W*(p%FPW) +: FSEL_W] = fsel_q[p];
      end
   end

   always_comb begin
      fsel_d     = fsel_q;
      db_en_d    = db_en_q;
      irq_en_d   = irq_en_q;
      db_limit_d = db_limit_q;
      stat_clr   = '0;
      if (wr) begin
         if (off < OFF_DB_EN_LO) begin
            // FSEL fields may straddle byte lanes, so byte enables are applied per bit.
            for (int p = 0; p < NUM_PADS; p++)
               if (p / FPW == int'(wbs_adr_i[7:2]))
                  for (int b = 0; b < FSEL_W; b++)
                     if (wbs_sel_i[(FSEL_W*(p%FPW)+b)/8])
                        fsel_d[p][b] = wbs_dat_i[FSEL_W*(p%FPW)+b];
         end else begin
            case (off)
               OFF_DB_EN_LO:    db_en_d[31:0]           = byte_merge(db_en_q[31:0], wbs_dat_i, wbs_sel_i);
               OFF_DB_EN_HI:    db_en_d[MAX_PADS-1:32]  = byte_merge(db_en_q[MAX_PADS-1:32], wbs_dat_i, wbs_sel_i);
               OFF_IRQ_EN_LO:   irq_en_d[31:0]          = byte_merge(irq_en_q[31:0], wbs_dat_i, wbs_sel_i);
               OFF_IRQ_EN_HI:   irq_en_d[MAX_PADS-1:32] = byte_merge(irq_en_q[MAX_PADS-1:32], wbs_dat_i, wbs_sel_i);
               OFF_IRQ_STAT_LO: stat_clr[31:0]          = wbs_dat_i & byte_mask(wbs_sel_i);
               OFF_IRQ_STAT_HI: stat_clr[MAX_PADS-1:32] = wbs_dat_i & byte_mask(wbs_sel_i);
               OFF_DB_LIMIT: begin
                  for (int i = 0; i < DB_W; i++)
                     if (wbs_sel_i[i/8]) db_limit_d[i] = wbs_dat_i[i];
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         rd_q       <= '0;
         fsel_q     <= '0;
         db_en_q    <= '0;
         irq_en_q   <= '0;
         irq_stat_q <= '0;
         db_limit_q <= '0;
         irq_o      <= 1'b0;
      end else begin
         rd_q       <= req ? rd_d : 32'h0;
         fsel_q     <= fsel_d;
         db_en_q    <= db_en_d & PAD_MASK;
         irq_en_q   <= irq_en_d & PAD_MASK;
         db_limit_q <= db_limit_d;
         // A new edge on the same bit as a W1C keeps the bit set.
         irq_stat_q <= ((irq_stat_q & ~stat_clr) | (rise_x & irq_en_q)) & PAD_MASK;
         irq_o      <= |(irq_stat_q & irq_en_q);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         io_out <= {NUM_PADS{RST_OUT}};
         io_oeb <= {NUM_PADS{RST_OEB}};
      end else begin
         for (int p = 0; p < NUM_PADS; p++) begin
            io_out[p] <= periph_o[IDX_W'(int'(fsel_q[p]) * NUM_PADS + p)];
            io_oeb[p] <= ~periph_oe[IDX_W'(int'(fsel_q[p]) * NUM_PADS + p)];
         end
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      azadi_io_filter #(.DB_W(DB_W)) u_filter (
         .clk      (wb_clk_i),
         .rst      (wb_rst_i),
         .pad      (io_in[p]),
         .db_en    (db_en_q[p]),
         .db_limit (db_limit_q),
         .filt     (pad_f[p]),
         .rise     (pad_rise[p])
      );
   end

endmodule

// File: tb/tb_azadi_io_mux.sv
// Self-checking bench for azadi_io_mux: directed scenarios plus randomized mux and input-history checks.
module tb_azadi_io_mux;

   localparam int          NP   = 38;
   localparam int          NF   = 4;
   localparam int          FPW  = 16;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic             wb_clk_i, wb_rst_i;
   logic             wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]       wbs_sel_i;
   logic [31:0]      wbs_adr_i, wbs_dat_i;
   logic             wbs_ack_o;
   logic [31:0]      wbs_dat_o;
   logic [NF*NP-1:0] periph_o, periph_oe;
   logic [NP-1:0]    pad_in_o, io_in, io_out, io_oeb;
   logic             irq_o;

   int checks = 0;
   int errors = 0;
   logic [1:0] fsel_m [NP];

   azadi_io_mux dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .periph_o(periph_o), .periph_oe(periph_oe), .pad_in_o(pad_in_o),
      .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq_o(irq_o)
   );

   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
      $fatal(1, "watchdog expired");
   end

   task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat);
      bit got;
      @(posedge wb_clk_i); #1;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
      got = 1'b0; rdat = 32'h0;
      for (int i = 0; i < 16 && !got; i++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) begin got = 1'b1; rdat = wbs_dat_o; end
      end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL wb_ack_timeout adr=%h: ack=0, required ack within 16 cycles", adr);
      end
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] dummy;
      wb_xfer(adr, 1'b1, dat, sel, dummy);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
      wb_xfer(adr, 1'b0, 32'h0, 4'hF, dat);
   endtask

   function automatic logic [NF*NP-1:0] rand_vec();
      logic [NF*NP-1:0] v;
      for (int i = 0; i < NF*NP; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge wb_clk_i);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
      io_in = '0; periph_o = '1; periph_oe = '1;
      wait_cycles(4);
      checks++; if (io_oeb !== {NP{1'b1}}) begin errors++; $display("FAIL rst_io_oeb: got %h required all ones", io_oeb); end
      checks++; if (io_out !== '0) begin errors++; $display("FAIL rst_io_out: got %h required 0", io_out); end
      checks++; if (pad_in_o !== '0) begin errors++; $display("FAIL rst_pad_in: got %h required 0", pad_in_o); end
      checks++; if ({irq_o, wbs_ack_o} !== 2'b00) begin errors++; $display("FAIL rst_irq_ack: got irq=%b ack=%b required 0 0", irq_o, wbs_ack_o); end
      checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat_o: got %h required 0", wbs_dat_o); end
      periph_o = '0; periph_oe = '0;
      wb_rst_i = 1'b0;
      wait_cycles(2);
      for (int a = 0; a <= 32'h60; a += 4) begin
         wb_read(BASE + 32'(a), r);
         checks++;
         if (r !== 32'h0) begin errors++; $display("FAIL rst_reg off=%h: got %h required 0", a, r); end
      end
   endtask

   task automatic test_bus_lanes();
      logic [31:0] r, lim_m, m;
      bit seen;
      lim_m = 32'h0;
      // DB_LIMIT model: only the low 8 implemented bits keep data, per enabled byte lane.
      wb_write(BASE + 32'h48, 32'hFFFF_FFFF, 4'b0010);
      m = {{8{1'b0}}, {8{1'b0}}, {8{1'b1}}, {8{1'b0}}} & 32'h0000_00FF;
      lim_m = (lim_m & ~m) | (32'hFFFF_FFFF & m);
      wb_read(BASE + 32'h48, r);
      checks++; if (r !== lim_m) begin errors++; $display("FAIL sel_byte1_limit: got %h required %h", r, lim_m); end
      checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL dat_o_after_ack: got %h required 0", wbs_dat_o); end
      wait_cycles(1);
      checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL ack_single_cycle: got %b required 0", wbs_ack_o); end
      wb_write(BASE + 32'h48, 32'h1234_56A5, 4'b0001);
      wb_read(BASE + 32'h48, r);
      checks++; if (r !== 32'h0000_00A5) begin errors++; $display("FAIL sel_byte0_limit: got %h required %h", r, 32'h0000_00A5); end
      wb_write(BASE + 32'h48, 32'h0, 4'hF);
      wb_write(BASE + 32'h44, 32'hFFFF_FFFF, 4'hF);
      wb_read(BASE + 32'h44, r);
      checks++; if (r !== (32'h1 << (NP - 32)) - 32'h1) begin errors++; $display("FAIL db_en_hi_mask: got %h required %h", r, (32'h1 << (NP - 32)) - 32'h1); end
      wb_write(BASE + 32'h44, 32'h0, 4'hF);
      wb_write(BASE + 32'h80, 32'hFFFF_FFFF, 4'hF);
      wb_read(BASE + 32'h80, r);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_0x80: got %h required 0", r); end
      @(posedge wb_clk_i); #1;
      wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h100;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin @(posedge wb_clk_i); #1; if (wbs_ack_o) seen = 1'b1; end
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL out_of_window_ack: got ack=1 required no ack"); end
   endtask

   task automatic test_fsel_mux();
      logic [31:0] r;
      @(posedge wb_clk_i); #1;
      periph_o = '0; periph_oe = '0;
      periph_o[0] = 1'b1; periph_oe[0] = 1'b1;
      periph_o[1*NP+1] = 1'b1; periph_oe[1*NP+1] = 1'b1;
      wait_cycles(2);
      checks++; if ({io_oeb[1], io_out[0], io_oeb[0]} !== 3'b110) begin errors++; $display("FAIL fsel_before: got oeb1/out0/oeb0=%b required 110", {io_oeb[1], io_out[0], io_oeb[0]}); end
      wb_write(BASE + 32'h00, 32'h0000_0004, 4'hF);
      checks++; if (io_oeb[1] !== 1'b1) begin errors++; $display("FAIL fsel_ack_cycle: got io_oeb[1]=%b required 1", io_oeb[1]); end
      wait_cycles(1);
      checks++; if ({io_oeb[1], io_out[1]} !== 2'b01) begin errors++; $display("FAIL fsel_after: got oeb1/out1=%b required 01", {io_oeb[1], io_out[1]}); end
      checks++; if ({io_out[0], io_oeb[0]} !== 2'b10) begin errors++; $display("FAIL fsel_pad0_func0: got out0/oeb0=%b required 10", {io_out[0], io_oeb[0]}); end
      wb_read(BASE + 32'h00, r);
      checks++; if (r !== 32'h0000_0004) begin errors++; $display("FAIL fsel_readback: got %h required 4", r); end
      wb_write(BASE + 32'h00, 32'h0, 4'hF);
      periph_o = '0; periph_oe = '0;
   endtask

   task automatic test_debounce();
      logic [31:0] r;
      bit seen;
      int n;
      wb_write(BASE + 32'h40, 32'h1 << 5, 4'hF);
      wb_write(BASE + 32'h48, 32'd10, 4'hF);
      @(posedge wb_clk_i); #1; io_in[5] = 1'b1;
      wait_cycles(6);
      io_in[5] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin @(posedge wb_clk_i); #1; if (pad_in_o[5]) seen = 1'b1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL db_glitch: got pad_in_o[5] high required stays 0"); end
      @(posedge wb_clk_i); #1; io_in[5] = 1'b1;
      n = 0;
      for (int i = 1; i <= 40 && n == 0; i++) begin @(posedge wb_clk_i); #1; if (pad_in_o[5]) n = i; end
      checks++; if (n != 3 + 10) begin errors++; $display("FAIL db_level_latency: got %0d cycles required %0d", n, 13); end
      wb_read(BASE + 32'h5C, r);
      checks++; if (r[5] !== 1'b1) begin errors++; $display("FAIL db_pad_in_reg: got %h required bit5 set", r); end
      io_in[5] = 1'b0;
      wait_cycles(20);
      wb_write(BASE + 32'h48, 32'd0, 4'hF);
      @(posedge wb_clk_i); #1; io_in[5] = 1'b1;
      n = 0;
      for (int i = 1; i <= 40 && n == 0; i++) begin @(posedge wb_clk_i); #1; if (pad_in_o[5]) n = i; end
      checks++; if (n != 3) begin errors++; $display("FAIL db_limit0_latency: got %0d cycles required 3", n); end
      io_in[5] = 1'b0;
      wb_write(BASE + 32'h40, 32'h0, 4'hF);
      wait_cycles(6);
   endtask

   task automatic test_irq();
      logic [31:0] r;
      int n;
      wb_write(BASE + 32'h4C, 32'h1 << 3, 4'hF);
      @(posedge wb_clk_i); #1; io_in[3] = 1'b1;
      n = 0;
      for (int i = 1; i <= 20 && n == 0; i++) begin @(posedge wb_clk_i); #1; if (irq_o) n = i; end
      checks++; if (n != 5) begin errors++; $display("FAIL irq_latency: got %0d cycles required 5", n); end
      wb_read(BASE + 32'h54, r);
      checks++; if (r !== 32'h8) begin errors++; $display("FAIL irq_stat_set: got %h required 8", r); end
      wb_write(BASE + 32'h54, 32'h8, 4'hF);
      checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_w1c_ack_cycle: got %b required 1", irq_o); end
      wait_cycles(1);
      checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_w1c_clear: got %b required 0", irq_o); end
      @(posedge wb_clk_i); #1; io_in[4] = 1'b1;
      wait_cycles(8);
      wb_read(BASE + 32'h54, r);
      checks++; if ({r, irq_o} !== 33'h0) begin errors++; $display("FAIL irq_disabled_pad: got stat=%h irq=%b required 0 0", r, irq_o); end
      io_in[4] = 1'b0;
   endtask

   task automatic test_irq_collision();
      logic [31:0] r;
      @(posedge wb_clk_i); #1; io_in[3] = 1'b0;
      wait_cycles(8);
      @(posedge wb_clk_i); #1; io_in[3] = 1'b1;
      repeat (2) @(posedge wb_clk_i);
      // The W1C lands on the same edge that records the filtered rise.
      wb_write(BASE + 32'h54, 32'h8, 4'hF);
      wb_read(BASE + 32'h54, r);
      checks++; if (r !== 32'h8) begin errors++; $display("FAIL irq_set_beats_clear: got %h required 8", r); end
      checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_after_collision: got %b required 1", irq_o); end
      wb_write(BASE + 32'h54, 32'h8, 4'hF);
      io_in[3] = 1'b0;
      wait_cycles(6);
   endtask

   task automatic test_random_mux();
      logic [31:0] w, r;
      logic [NP-1:0] eo, eoeb;
      int k;
      for (int it = 0; it < 12; it++) begin
         for (int p = 0; p < NP; p++) fsel_m[p] = 2'($urandom_range(0, NF - 1));
         @(posedge wb_clk_i); #1;
         periph_o = rand_vec(); periph_oe = rand_vec();
         for (int wd = 0; wd < (NP + FPW - 1) / FPW; wd++) begin
            w = 32'h0;
            for (int p = 0; p < NP; p++) if (p / FPW == wd) w[2*(p%FPW) +: 2] = fsel_m[p];
            wb_write(BASE + 32'(4*wd), w, 4'hF);
         end
         wait_cycles(1);
         for (int p = 0; p < NP; p++) begin
            eo[p] = periph_o[int'(fsel_m[p])*NP + p];
            eoeb[p] = ~periph_oe[int'(fsel_m[p])*NP + p];
         end
         checks++; if ({io_out, io_oeb} !== {eo, eoeb}) begin errors++; $display("FAIL rand_mux it=%0d: got out=%h oeb=%h required out=%h oeb=%h", it, io_out, io_oeb, eo, eoeb); end
         periph_o = rand_vec(); periph_oe = rand_vec();
         wait_cycles(1);
         for (int p = 0; p < NP; p++) begin
            eo[p] = periph_o[int'(fsel_m[p])*NP + p];
            eoeb[p] = ~periph_oe[int'(fsel_m[p])*NP + p];
         end
         checks++; if ({io_out, io_oeb} !== {eo, eoeb}) begin errors++; $display("FAIL rand_periph it=%0d: got out=%h oeb=%h required out=%h oeb=%h", it, io_out, io_oeb, eo, eoeb); end
         k = $urandom_range(0, 2);
         w = 32'h0;
         for (int p = 0; p < NP; p++) if (p / FPW == k) w[2*(p%FPW) +: 2] = fsel_m[p];
         wb_read(BASE + 32'(4*k), r);
         checks++; if (r !== w) begin errors++; $display("FAIL rand_fsel_read word=%0d: got %h required %h", k, r, w); end
      end
   endtask

   task automatic test_random_input();
      logic [NP-1:0] hist [$];
      logic [63:0] e;
      logic [31:0] r;
      for (int k = 0; k < 60; k++) begin
         @(posedge wb_clk_i); #1;
         if (hist.size() >= 3) begin
            checks++;
            if (pad_in_o !== hist[hist.size()-3]) begin errors++; $display("FAIL pad_hist step=%0d: got %h required %h", k, pad_in_o, hist[hist.size()-3]); end
         end
         io_in = NP'({$urandom(), $urandom()});
         hist.push_back(io_in);
      end
      wait_cycles(4);
      e = 64'(io_in);
      wb_read(BASE + 32'h5C, r);
      checks++; if (r !== e[31:0]) begin errors++; $display("FAIL pad_in_lo: got %h required %h", r, e[31:0]); end
      wb_read(BASE + 32'h60, r);
      checks++; if (r !== e[63:32]) begin errors++; $display("FAIL pad_in_hi: got %h required %h", r, e[63:32]); end
   endtask

   initial begin
      test_reset();
      test_bus_lanes();
      test_fsel_mux();
      test_debounce();
      test_irq();
      test_irq_collision();
      test_random_mux();
      test_random_input();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
